cliff_burst_seq: RTL and testbench

//  Parametrised read-cycle sequencer; successor to the single-channel go/ws/rd/rs FSM.

---
 rtl/cliff_pkg.sv | 26 ++
 rtl/cliff_rr_arb.sv | 50 +++++
 rtl/cliff_burst_seq.sv | 123 ++++++++++++
 tb/tb_cliff_burst_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cliff_pkg.sv
// cliff_pkg: shared definitions for the cliff burst read sequencer.
//   state_t    : 3-bit binary FSM encoding (IDLE, READ, DLY, DONE, TMO)
//   state_name : 4-character ASCII label of a state, used for the debug
//                statename register in the top.
package cliff_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_DLY  = 3'd2,
    S_DONE = 3'd3,
    S_TMO  = 3'd4
  } state_t;

  function automatic logic [8*4-1:0] state_name(input state_t s);
    case (s)
      S_IDLE:  return "IDLE";
      S_READ:  return "READ";
      S_DLY:   return "DLY ";
      S_DONE:  return "DONE";
      S_TMO:   return "TMO ";
      default: return "????";
    endcase
  endfunction

endpackage

// File: rtl/cliff_rr_arb.sv
// cliff_rr_arb: round-robin arbiter that owns the rotating priority pointer.
//   clk, rst  : clock, synchronous active-high reset (pointer -> channel 0)
//   req       : per-channel request levels
//   advance   : a grant is being taken this cycle; pointer moves past winner
//   gnt       : one-hot grant (combinational from req and pointer)
//   gnt_idx   : binary index of the granted channel
// Highest priority is the pointer channel, i.e. the one after the last grant.
module cliff_rr_arb
  import cliff_pkg::*;
#(
  parameter  int NUM_CH = 2,
  localparam int IW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] gnt,
  output logic [IW-1:0]     gnt_idx
);

  logic [IW-1:0] ptr;
  logic          found;
  int            c;

  // Scan from the pointer upward, wrapping, and take the first requester.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    c       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = int'(ptr) + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!found && req[c]) begin
        found   = 1'b1;
        gnt[c]  = 1'b1;
        gnt_idx = IW'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (advance && found)
      ptr <= (gnt_idx == IW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
  end

endmodule

// File: rtl/cliff_burst_seq.sv
// cliff_burst_seq: round-robin burst read sequencer for a slow strobe target.
//   clk       : rising-edge clock
//   rst       : synchronous reset, active-high
//   go        : per-channel request levels (NUM_CH)
//   ws        : target wait-state, only looked at in DLY
//   rd        : read strobe, high in READ and DLY
//   rs        : one-cycle read-done pulse (DONE)
//   err       : one-cycle timeout pulse (TMO)
//   busy      : high in every state except IDLE
//   ch_sel    : granted channel, captured at grant
//   beat_cnt  : current beat index within the burst
// All outputs are registers loaded from the next-state decision, so they
// change on the same edge as the state and no input reaches an output
// combinationally.
module cliff_burst_seq
  import cliff_pkg::*;
#(
  parameter  int NUM_CH    = 2,
  parameter  int BURST_LEN = 4,
  parameter  int WS_MAX    = 3,
  localparam int IW        = (NUM_CH > 1)    ? $clog2(NUM_CH)    : 1,
  localparam int BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] go,
  input  logic              ws,
  output logic              rd,
  output logic              rs,
  output logic              err,
  output logic              busy,
  output logic [IW-1:0]     ch_sel,
  output logic [BW-1:0]     beat_cnt
);

  localparam int            WW        = (WS_MAX > 1) ? $clog2(WS_MAX) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WS_MAX - 1);

  state_t              state;
  logic   [WW-1:0]     wait_cnt;
  logic   [NUM_CH-1:0] gnt;
  logic   [IW-1:0]     gnt_idx;
  logic                gnt_vld;
  logic                take;

  // Debug label of the current state for waveform viewing.
  logic   [8*4-1:0]    statename;
  assign statename = state_name(state);

  assign gnt_vld = |gnt;
  assign take    = (state == S_IDLE) && gnt_vld;

  cliff_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (go),
    .advance (take),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rd       <= 1'b0;
      rs       <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      ch_sel   <= '0;
      beat_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      // Strobes are single-cycle; only DLY exits raise them.
      rs  <= 1'b0;
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (take) begin
            state    <= S_READ;
            rd       <= 1'b1;
            busy     <= 1'b1;
            ch_sel   <= gnt_idx;
            beat_cnt <= '0;
            wait_cnt <= '0;
          end
        end
        S_READ: state <= S_DLY;
        S_DLY: begin
          if (ws) begin
            if (wait_cnt == WAIT_LAST) begin
              state <= S_TMO;
              rd    <= 1'b0;
              err   <= 1'b1;
            end else begin
              state    <= S_READ;
              wait_cnt <= wait_cnt + 1'b1;
            end
          end else if (beat_cnt == BEAT_LAST) begin
            state <= S_DONE;
            rd    <= 1'b0;
            rs    <= 1'b1;
          end else begin
            state    <= S_READ;
            beat_cnt <= beat_cnt + 1'b1;
            wait_cnt <= '0;
          end
        end
        S_DONE, S_TMO: begin
          state <= S_IDLE;
          rd    <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          rd    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cliff_burst_seq.sv
module tb_cliff_burst_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] go;
  logic       ws;
  logic       rd, rs, err, busy;
  logic [0:0] ch_sel;
  logic [1:0] beat_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  cliff_burst_seq #(.NUM_CH(2), .BURST_LEN(4), .WS_MAX(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .ws       (ws),
    .rd       (rd),
    .rs       (rs),
    .err      (err),
    .busy     (busy),
    .ch_sel   (ch_sel),
    .beat_cnt (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".rd"},   32'(rd),   32'd0);
    chk({tag, ".rs"},   32'(rs),   32'd0);
    chk({tag, ".err"},  32'(err),  32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".name"}, dut.statename, "IDLE");
  endtask

  initial begin
    // Reset 5 cycles
    rst = 1'b1; go = 2'b00; ws = 1'b0;
    repeat (5) step();
    rst = 1'b0;
    step();
    chk_idle("rst");
    chk("rst.ch_sel", 32'(ch_sel),   32'd0);
    chk("rst.beat",   32'(beat_cnt), 32'd0);

    // Single burst on ch0, no wait states
    go = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) begin
        go = 2'b00;
        chk("b1.ch_sel", 32'(ch_sel), 32'd0);
      end
      chk("b1.rd",   32'(rd),       32'd1);
      chk("b1.beat", 32'(beat_cnt), 32'((k - 1) / 2));
      chk("b1.rs",   32'(rs),       32'd0);
    end
    step();
    chk("b1.done.rs",   32'(rs),   32'd1);
    chk("b1.done.rd",   32'(rd),   32'd0);
    chk("b1.done.busy", 32'(busy), 32'd1);
    chk("b1.done.name", dut.statename, "DONE");
    step();
    chk_idle("b1.idle");

    // Round-robin with both channels held; reset first so ch0 leads
    rst = 1'b1;
    step();
    rst = 1'b0;
    go = 2'b11;
    for (int b = 0; b < 3; b++) begin
      step();
      chk("rr.ch_sel", 32'(ch_sel), 32'(b % 2));
      chk("rr.busy",   32'(busy),   32'd1);
      repeat (7) step();
      chk("rr.rd_last", 32'(rd), 32'd1);
      step();
      chk("rr.rs", 32'(rs), 32'd1);
      step();
      if (b == 2) go = 2'b00;
      chk("rr.idle_gap", 32'(busy), 32'd0);
    end

    // Two wait states in beat 1
    go = 2'b01; ws = 1'b0;
    step();                                 // READ b0
    go = 2'b00;
    step();                                 // DLY b0
    step();                                 // READ b1
    chk("ws.beat1", 32'(beat_cnt), 32'd1);
    step();                                 // DLY b1
    chk("ws.dly", dut.statename, "DLY ");
    ws = 1'b1;
    step();                                 // READ b1 retry 1
    chk("ws.retry1.beat", 32'(beat_cnt), 32'd1);
    chk("ws.retry1.rd",   32'(rd),       32'd1);
    step();                                 // DLY
    step();                                 // READ retry 2
    step();                                 // DLY
    chk("ws.retry2.beat", 32'(beat_cnt), 32'd1);
    ws = 1'b0;
    step();                                 // READ b2
    chk("ws.beat2", 32'(beat_cnt), 32'd2);
    repeat (3) step();
    chk("ws.rs_early", 32'(rs), 32'd0);
    step();
    chk("ws.rs",  32'(rs),  32'd1);
    chk("ws.err", 32'(err), 32'd0);
    step();
    chk_idle("ws.idle");

    // Timeout: ws held from the start
    go = 2'b01; ws = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) go = 2'b00;
      chk("tmo.rd",  32'(rd),  32'd1);
      chk("tmo.err", 32'(err), 32'd0);
      chk("tmo.beat", 32'(beat_cnt), 32'd0);
    end
    step();
    chk("tmo.err_pulse", 32'(err),  32'd1);
    chk("tmo.rs",        32'(rs),   32'd0);
    chk("tmo.rd_off",    32'(rd),   32'd0);
    chk("tmo.busy",      32'(busy), 32'd1);
    chk("tmo.name",      dut.statename, "TMO ");
    ws = 1'b0;
    step();
    chk_idle("tmo.idle");

    // Reset during beat 2
    go = 2'b10;
    step();
    chk("mid.ch_sel", 32'(ch_sel), 32'd1);
    go = 2'b00;
    repeat (4) step();
    chk("mid.beat2", 32'(beat_cnt), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("mid.rst");
    chk("mid.rst.beat", 32'(beat_cnt), 32'd0);
    chk("mid.rst.ch",   32'(ch_sel),   32'd0);
    step();
    chk("mid.quiet.rs",  32'(rs),  32'd0);
    chk("mid.quiet.err", 32'(err), 32'd0);
    go = 2'b10;
    step();
    chk("mid.regrant.ch", 32'(ch_sel), 32'd1);
    chk("mid.regrant.rd", 32'(rd),     32'd1);
    go = 2'b00;
    repeat (8) step();
    chk("mid.regrant.rs", 32'(rs), 32'd1);
    step();
    chk_idle("mid.end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
